// File: rtl/pc_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit_pkg
//   Shared definitions for the PC / instruction-fetch unit of the multi-cycle
//   core: data width, default reset vector, fetch FSM state encoding and a
//   word-alignment helper.
// -----------------------------------------------------------------------------
package pc_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // S_FETCH : request outstanding to instruction memory
    // S_EXEC  : instruction latched, waiting for the core to retire it
    // S_TRAP  : misaligned redirect seen, frozen until reset
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_TRAP  = 2'd2
    } state_t;

    // Clear the two byte-offset bits of an address.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
//   Purely combinational next-PC selection.
//   Ports:
//     pc           in   current program counter
//     imm          in   sign-extended B/J/I immediate
//     rs1_val      in   rs1 operand (JALR base)
//     taken_branch in   redirect taken
//     is_jalr      in   use the register-relative JALR form
//     next_pc      out  selected next PC (32-bit modulo arithmetic)
//     misaligned   out  next_pc is not word aligned
// -----------------------------------------------------------------------------
module next_pc_calc
    import pc_fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            taken_branch,
    input  logic            is_jalr,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    always_comb begin
        next_pc = pc + 32'd4;
        if (taken_branch) begin
            if (is_jalr) begin
                // JALR discards bit 0 of the computed target.
                next_pc = (rs1_val + imm) & ~32'h1;
            end else begin
                next_pc = pc + imm;
            end
        end
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Owns the program counter, fetches one instruction at a time from
//   instruction memory and advances / redirects the PC when the core retires.
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     pc_update          retire strobe from the core FSM (honoured in S_EXEC)
//     taken_branch       redirect taken (sampled with pc_update)
//     is_jalr            JALR target form (sampled with pc_update)
//     imm, rs1_val       target operands
//     imem_req/addr      fetch request and address (addr == pc)
//     imem_ready/rdata   memory response
//     instr, instr_valid latched instruction and its validity
//     pc, pc_plus4       current PC and link value
//     misaligned_trap    sticky instruction-address-misaligned flag
// -----------------------------------------------------------------------------
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_update,
    input  logic        taken_branch,
    input  logic        is_jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned_trap
);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              trap_q, trap_d;
    logic              req_q, req_d;

    logic [XLEN-1:0]   next_pc;
    logic              next_misaligned;

    next_pc_calc u_next_pc (
        .pc           (pc_q),
        .imm          (imm),
        .rs1_val      (rs1_val),
        .taken_branch (taken_branch),
        .is_jalr      (is_jalr),
        .next_pc      (next_pc),
        .misaligned   (next_misaligned)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        trap_d  = trap_q;

        case (state_q)
            S_FETCH: begin
                // Only a response to a request we actually raised counts;
                // ready during the first post-reset cycle is ignored.
                if (req_q && imem_ready) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (pc_update) begin
                    valid_d = 1'b0;
                    if (ALIGN_CHECK && next_misaligned) begin
                        trap_d  = 1'b1;
                        state_d = S_TRAP;
                    end else begin
                        pc_d    = word_align(next_pc);
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                // S_TRAP (and the unused encoding): frozen until reset.
                state_d = S_TRAP;
            end
        endcase

        // The request is registered so that it is low throughout reset and
        // rises on the first edge after release, and on the same edge that
        // commits a new PC -- never with a stale address.
        req_d = (state_d == S_FETCH);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            trap_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            trap_q  <= trap_d;
            req_q   <= req_d;
        end
    end

    assign imem_req        = req_q;
    assign imem_addr       = pc_q;
    assign pc              = pc_q;
    assign pc_plus4        = pc_q + 32'd4;
    assign instr           = instr_q;
    assign instr_valid     = valid_q;
    assign misaligned_trap = trap_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Self-checking bench for pc_fetch_unit: directed scenarios followed by
//   randomized traffic, all compared against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_update = 1'b0;
    logic        taken_branch = 1'b0;
    logic        is_jalr = 1'b0;
    logic [31:0] imm = '0;
    logic [31:0] rs1_val = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned_trap;

    pc_fetch_unit #(.RESET_PC(RST_PC), .ALIGN_CHECK(1'b1)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_update       (pc_update),
        .taken_branch    (taken_branch),
        .is_jalr         (is_jalr),
        .imm             (imm),
        .rs1_val         (rs1_val),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .misaligned_trap (misaligned_trap)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Phases of one instruction's life: just out of reset, waiting for memory,
    // waiting for retirement, or dead after a misaligned redirect.
    typedef enum {M_BOOT, M_FETCH, M_EXEC, M_TRAP} mphase_t;

    mphase_t     m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_trap;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase = M_BOOT;
        m_pc    = RST_PC;
        m_instr = '0;
        m_valid = 1'b0;
        m_trap  = 1'b0;
    endfunction

    // Advance the model by one rising edge given the inputs seen at that edge.
    function automatic void model_edge(input logic upd, input logic tkn, input logic jr,
                                       input logic [31:0] im, input logic [31:0] rs,
                                       input logic rdy, input logic [31:0] rd);
        logic [31:0] sum;
        logic [31:0] tgt;
        case (m_phase)
            M_BOOT: m_phase = M_FETCH;
            M_FETCH: if (rdy) begin
                m_instr = rd;
                m_valid = 1'b1;
                m_phase = M_EXEC;
            end
            M_EXEC: if (upd) begin
                sum = rs + im;
                if (!tkn)     tgt = m_pc + 32'd4;
                else if (!jr) tgt = m_pc + im;
                else          tgt = sum - (sum % 2);
                m_valid = 1'b0;
                if (tgt % 4 != 0) begin
                    m_trap  = 1'b1;
                    m_phase = M_TRAP;
                end else begin
                    m_pc    = tgt;
                    m_phase = M_FETCH;
                end
            end
            default: ;
        endcase
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("imem_req",        32'(imem_req),        32'(m_phase == M_FETCH));
        check("imem_addr",       imem_addr,            m_pc);
        check("pc",              pc,                   m_pc);
        check("pc_plus4",        pc_plus4,             m_pc + 32'd4);
        check("instr_valid",     32'(instr_valid),     32'(m_valid));
        check("instr",           instr,                m_instr);
        check("misaligned_trap", 32'(misaligned_trap), 32'(m_trap));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input logic upd, input logic tkn, input logic jr,
                         input logic [31:0] im, input logic [31:0] rs,
                         input logic rdy, input logic [31:0] rd);
        pc_update    = upd;
        taken_branch = tkn;
        is_jalr      = jr;
        imm          = im;
        rs1_val      = rs;
        imem_ready   = rdy;
        imem_rdata   = rd;
        @(posedge clk);
        if (rst_n) model_edge(upd, tkn, jr, im, rs, rdy, rd);
        #1;
    endtask

    task automatic fetch_ok(input logic [31:0] rd);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, rd);
    endtask

    task automatic retire(input logic tkn, input logic jr, input logic [31:0] im, input logic [31:0] rs);
        cycle(1'b1, tkn, jr, im, rs, 1'b0, '0);
    endtask

    // Asynchronous assertion mid-cycle, synchronous-style release later.
    task automatic hit_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_req_drop",   32'(imem_req),        32'd0);
        check("rst_trap_clear", 32'(misaligned_trap), 32'd0);
        check("rst_valid",      32'(instr_valid),     32'd0);
        check("rst_addr",       imem_addr,            RST_PC);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Reset fetch, zero wait: ready held high from release.
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 32'h0000_0013);
        check("t1_req",  32'(imem_req), 32'd1);
        check("t1_addr", imem_addr,     32'h0);
        fetch_ok(32'h0000_0013);
        check("t1_valid", 32'(instr_valid), 32'd1);
        check("t1_instr", instr,            32'h0000_0013);

        // Sequential advance, then three wait states on the next fetch.
        retire(1'b0, 1'b0, 32'h1234_5678, '0);
        check("t2_addr", imem_addr, 32'h4);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 32'hDEAD_BEEF);
            check("t2_wait_req",  32'(imem_req), 32'd1);
            check("t2_wait_addr", imem_addr,     32'h4);
        end
        fetch_ok(32'h0040_0093);
        check("t2_instr", instr, 32'h0040_0093);

        // JAL forward to 0x100, then backward branch to 0xF0.
        retire(1'b1, 1'b0, 32'h0000_00FC, '0);
        check("t3_jal_addr", imem_addr, 32'h100);
        fetch_ok(32'hFE00_08E3);
        retire(1'b1, 1'b0, 32'hFFFF_FFF0, '0);
        check("t3_bwd_addr", imem_addr,                32'hF0);
        check("t3_no_trap",  32'(misaligned_trap),     32'd0);
        fetch_ok(32'h0040_8067);

        // JALR with bit 0 of the sum cleared.
        check("t4_link", pc_plus4, 32'hF4);
        retire(1'b1, 1'b1, 32'h4, 32'h0000_2001);
        check("t4_jalr_addr", imem_addr, 32'h2004);
        fetch_ok(32'h0000_0013);

        // Get to 0x10, then a misaligned taken branch.
        retire(1'b1, 1'b0, 32'hFFFF_E00C, '0);
        check("t5_addr", imem_addr, 32'h10);
        fetch_ok(32'h0060_0063);
        retire(1'b1, 1'b0, 32'h6, '0);
        check("t5_trap", 32'(misaligned_trap), 32'd1);
        check("t5_pc",   pc,                   32'h10);
        for (int i = 0; i < 10; i++) begin
            cycle(1'($urandom), 1'b1, 1'b0, 32'h8, '0, 1'b1, $urandom);
            check("t5_req_low",  32'(imem_req),        32'd0);
            check("t5_trap_hold", 32'(misaligned_trap), 32'd1);
            check("t5_pc_hold",  pc,                   32'h10);
        end

        // Reset from trap, then reset mid-fetch with ready low.
        hit_reset();
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        check("t6_fetch_req", 32'(imem_req), 32'd1);
        hit_reset();
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        check("t6_rel_addr", imem_addr,     RST_PC);
        check("t6_rel_req",  32'(imem_req), 32'd1);
        fetch_ok(32'h0000_0013);

        // Modulo-2^32 wrap of the sequential address.
        retire(1'b1, 1'b0, 32'hFFFF_FFFC, '0);
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        fetch_ok(32'h0000_0013);
        check("wrap_link", pc_plus4, 32'h0);
        retire(1'b0, 1'b0, '0, '0);
        check("wrap_addr", imem_addr, 32'h0);

        // Randomized traffic; mostly aligned operands so traps stay occasional.
        for (int n = 0; n < 3000; n++) begin
            if (m_phase == M_TRAP && ($urandom % 4 == 0)) begin
                hit_reset();
            end else begin
                cycle(($urandom % 3) == 0,
                      1'($urandom),
                      1'($urandom),
                      ($urandom % 12 == 0) ? 32'($urandom) : (32'($urandom) & ~32'h3),
                      ($urandom % 8 == 0) ? 32'($urandom) : (32'($urandom) & ~32'h2),
                      1'($urandom),
                      32'($urandom));
            end
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
